// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared constants and state type for the bit serializer
package ser_pkg;

  localparam int   DEF_WIDTH     = 8;
  localparam logic DEF_IDLE_BIT  = 1'b0;
  localparam bit   DEF_MSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Counter width for a word of the given length; at least one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-in/serial-out stage with gapless word chaining
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter bit   MSB_FIRST = DEF_MSB_FIRST,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  input  logic             flush,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             x_n, x_valid_n, last_n, busy_n;
  logic             accept;

  // A new word may load while the final bit of the current one is on x.
  assign ready  = !flush && (state == ST_IDLE || cnt == LAST_CNT);
  assign accept = valid && ready;

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    x_n       = IDLE_BIT;
    x_valid_n = 1'b0;
    last_n    = 1'b0;
    busy_n    = 1'b0;

    if (flush) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else if (accept) begin
      state_n   = ST_SHIFT;
      sr_n      = data_in;
      cnt_n     = '0;
      x_n       = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
      x_valid_n = 1'b1;
      busy_n    = 1'b1;
    end else if (state == ST_SHIFT && cnt != LAST_CNT) begin
      sr_n      = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      cnt_n     = cnt + 1'b1;
      x_n       = MSB_FIRST ? sr_n[WIDTH-1] : sr_n[0];
      x_valid_n = 1'b1;
      busy_n    = 1'b1;
      last_n    = (cnt_n == LAST_CNT);
    end else begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      sr      <= '0;
      cnt     <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      x       <= x_n;
      x_valid <= x_valid_n;
      last    <= last_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for MSB-first and LSB-first serializers
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         valid = 1'b0;
  logic         flush = 1'b0;

  logic ready, x, x_valid, last, busy;
  logic ready_l, x_l, x_valid_l, last_l, busy_l;

  typedef struct {
    bit bm;
    bit bl;
    bit lst;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid), .ready(ready),
    .flush(flush), .x(x), .x_valid(x_valid), .last(last), .busy(busy)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid), .ready(ready_l),
    .flush(flush), .x(x_l), .x_valid(x_valid_l), .last(last_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Expected bit stream of one word, in emission order.
  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      exp_t e;
      e.bm  = d[W-1-i];
      e.bl  = d[i];
      e.lst = (i == W - 1);
      q.push_back(e);
    end
  endtask

  // Drive one cycle of inputs; the model decides acceptance from its own queue.
  task automatic step(input bit v, input logic [W-1:0] d, input bit f);
    valid   = v;
    data_in = d;
    flush   = f;
    @(posedge clk);
    if (!reset) q.delete();
    else if (f) q.delete();
    else if (v && q.size() == 0) push_word(d);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      chk("rst_x_valid", x_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_x_valid_lsb", x_valid_l, 1'b0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("x_valid", x_valid, 1'b1);
      chk("x_msb", x, e.bm);
      chk("x_lsb", x_l, e.bl);
      chk("last", last, e.lst);
      chk("last_lsb", last_l, e.lst);
      chk("busy", busy, 1'b1);
      chk("ready", ready, !flush && q.size() == 0);
      chk("ready_lsb", ready_l, !flush && q.size() == 0);
    end else begin
      chk("idle_x_valid", x_valid, 1'b0);
      chk("idle_x", x, 1'b0);
      chk("idle_x_lsb", x_l, 1'b0);
      chk("idle_last", last, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ready", ready, !flush);
    end
  end

  initial begin
    #3;
    chk("reset_x", x, 1'b0);
    chk("reset_x_valid", x_valid, 1'b0);
    chk("reset_last", last, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", ready, 1'b1);
    #5 reset = 1'b1;

    step(1'b1, 8'b10011000, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0);

    step(1'b1, 8'hA5, 1'b0);
    repeat (7) step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0);

    step(1'b1, 8'h01, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0);

    step(1'b1, 8'hFF, 1'b0);
    repeat (2) step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0);

    step(1'b1, 8'hC3, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("async_x", x, 1'b0);
    chk("async_x_valid", x_valid, 1'b0);
    chk("async_last", last, 1'b0);
    chk("async_busy", busy, 1'b0);
    q.delete();
    repeat (2) step(1'b0, '0, 1'b0);
    reset = 1'b1;
    chk("post_reset_ready", ready, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0);

    step(1'b1, 8'h96, 1'b0);
    repeat (10) step(1'b0, W'($urandom), 1'b0);

    repeat (20) step(1'b1, 8'h6C, 1'b0);

    repeat (400) step($urandom_range(9) < 7, W'($urandom), $urandom_range(39) == 0);

    repeat (12) step(1'b0, '0, 1'b0);
    chk("drain", q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
